// File: rtl/func_select_mux_pkg.sv
// Shared definitions for the VGA function selector: FSM encodings and the index-width helper.
package func_select_mux_pkg;

    typedef enum logic {
        ST_SWITCH = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Width of an index that can address n functions (never below one bit)
    function automatic int iw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/func_select_mux_if.sv
// Board-side bundle of the function selector: panel controls, shared buttons and colour buses.
interface func_select_mux_if #(
    parameter int NUM_FUNC = 3,
    parameter int CW       = 4,
    parameter int NUM_BTN  = 4
);
    logic                       power_sw;
    logic                       pixel_en;
    logic                       frame_tick;
    logic                       next_deb;
    logic                       prev_deb;
    logic [NUM_BTN-1:0]         btn_in;
    logic [NUM_FUNC*3*CW-1:0]   rgb_in;
    logic [NUM_FUNC*NUM_BTN-1:0] btn_out;
    logic [NUM_FUNC-1:0]        func_sel;
    logic [NUM_FUNC-1:0]        func_rst;
    logic [NUM_FUNC-1:0]        led;
    logic [CW-1:0]              R_out;
    logic [CW-1:0]              G_out;
    logic [CW-1:0]              B_out;

    modport master (
        output power_sw, pixel_en, frame_tick, next_deb, prev_deb, btn_in, rgb_in,
        input  btn_out, func_sel, func_rst, led, R_out, G_out, B_out
    );

    modport slave (
        input  power_sw, pixel_en, frame_tick, next_deb, prev_deb, btn_in, rgb_in,
        output btn_out, func_sel, func_rst, led, R_out, G_out, B_out
    );
endinterface

// File: rtl/func_select_mux_edge_detect.sv
// One-bit rising-edge detector on an already debounced level.
module func_select_mux_edge_detect (
    input  logic vgaclk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic d_p1;

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) d_p1 <= 1'b0;
        else       d_p1 <= d;
    end

    assign rise = d & ~d_p1;
endmodule

// File: rtl/func_select_mux.sv
// Selects one of NUM_FUNC VGA functions, blanks the screen for BLANK_FRAMES frames on
// every switch, routes the shared buttons to the active function and muxes its colour out.
module func_select_mux
    import func_select_mux_pkg::*;
#(
    parameter int NUM_FUNC     = 3,
    parameter int CW           = 4,
    parameter int NUM_BTN      = 4,
    parameter int BLANK_FRAMES = 2
) (
    input  logic             vgaclk,
    input  logic             reset,
    func_select_mux_if.slave bus
);
    localparam int IW = iw_of(NUM_FUNC);
    localparam int FW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [FW-1:0]       cnt, cnt_nxt;
    logic                next_rise, prev_rise;
    logic [NUM_FUNC-1:0] func_sel_r, led_r, sel_nxt, led_nxt;
    logic [3*CW-1:0]     rgb_slot [NUM_FUNC];
    logic [3*CW-1:0]     rgb_sel, rgb_p1;
    logic                rgb_on;

    func_select_mux_edge_detect u_next (
        .vgaclk(vgaclk), .reset(reset), .d(bus.next_deb), .rise(next_rise)
    );
    func_select_mux_edge_detect u_prev (
        .vgaclk(vgaclk), .reset(reset), .d(bus.prev_deb), .rise(prev_rise)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            ST_SWITCH: begin
                // Exit takes priority so a coincident frame_tick never overcounts
                if (cnt == FW'(BLANK_FRAMES)) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else if (bus.frame_tick) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (next_rise && !prev_rise) begin
                    idx_nxt   = (idx == IW'(NUM_FUNC - 1)) ? '0 : idx + 1'b1;
                    state_nxt = ST_SWITCH;
                end else if (prev_rise && !next_rise) begin
                    idx_nxt   = (idx == '0) ? IW'(NUM_FUNC - 1) : idx - 1'b1;
                    state_nxt = ST_SWITCH;
                end
            end
            default: state_nxt = ST_SWITCH;
        endcase
    end

    always_comb begin
        sel_nxt = '0;
        led_nxt = '0;
        for (int i = 0; i < NUM_FUNC; i++) begin
            sel_nxt[i] = (idx_nxt == IW'(i));
            led_nxt[i] = (IW'(i) <= idx_nxt);
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            state      <= ST_SWITCH;
            idx        <= '0;
            cnt        <= '0;
            func_sel_r <= NUM_FUNC'(1);
            led_r      <= NUM_FUNC'(1);
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            func_sel_r <= sel_nxt;
            led_r      <= led_nxt;
        end
    end

    for (genvar f = 0; f < NUM_FUNC; f++) begin : g_slot
        assign rgb_slot[f] = bus.rgb_in[f*3*CW +: 3*CW];
        assign bus.btn_out[f*NUM_BTN +: NUM_BTN] =
            (state == ST_ACTIVE && func_sel_r[f]) ? bus.btn_in : '0;
    end

    always_comb begin
        rgb_sel = '0;
        for (int f = 0; f < NUM_FUNC; f++) begin
            if (func_sel_r[f]) rgb_sel = rgb_slot[f];
        end
    end

    assign rgb_on = bus.power_sw & bus.pixel_en & (state == ST_ACTIVE);

    // Colour output stage: one register between selection and the pins
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) rgb_p1 <= '0;
        else       rgb_p1 <= rgb_on ? rgb_sel : '0;
    end

    assign bus.R_out    = rgb_p1[3*CW-1 -: CW];
    assign bus.G_out    = rgb_p1[2*CW-1 -: CW];
    assign bus.B_out    = rgb_p1[CW-1:0];
    assign bus.func_sel = func_sel_r;
    assign bus.led      = led_r;
    assign bus.func_rst = (state == ST_ACTIVE) ? ~func_sel_r : '1;
endmodule

// File: tb/tb_func_select_mux.sv
// Directed bench for func_select_mux with NUM_FUNC=3, CW=4, NUM_BTN=4, BLANK_FRAMES=2.
module tb_func_select_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    func_select_mux_if #(.NUM_FUNC(3), .CW(4), .NUM_BTN(4)) bus ();

    func_select_mux #(
        .NUM_FUNC(3), .CW(4), .NUM_BTN(4), .BLANK_FRAMES(2)
    ) dut (
        .vgaclk(clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
    endtask

    task automatic push_rgb(input logic [11:0] v);
        exp_q.push_back(v);
    endtask

    // Advance one clock and compare the registered colour against the oldest expectation
    task automatic step_rgb(input string tag);
        logic [11:0] e;
        step();
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, {bus.R_out, bus.G_out, bus.B_out});
        end else begin
            e = exp_q.pop_front();
            assert ({bus.R_out, bus.G_out, bus.B_out} === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, {bus.R_out, bus.G_out, bus.B_out}, e);
            end
        end
    endtask

    task automatic state_chk(input string tag, input logic [2:0] sel, input logic [2:0] led,
                             input logic [2:0] frst);
        chk({tag, "_sel"}, 32'(bus.func_sel), 32'(sel));
        chk({tag, "_led"}, 32'(bus.led), 32'(led));
        chk({tag, "_rst"}, 32'(bus.func_rst), 32'(frst));
    endtask

    task automatic pulse(input logic nx, input logic pv);
        bus.next_deb = nx;
        bus.prev_deb = pv;
        step();
        bus.next_deb = 1'b0;
        bus.prev_deb = 1'b0;
    endtask

    initial begin
        bus.power_sw   = 1'b1;
        bus.pixel_en   = 1'b1;
        bus.frame_tick = 1'b0;
        bus.next_deb   = 1'b0;
        bus.prev_deb   = 1'b0;
        bus.btn_in     = 4'b1111;
        bus.rgb_in     = {12'h3C7, 12'h5A3, 12'hF0A};

        // Reset state, with every input trying to leak through
        step();
        step();
        state_chk("reset", 3'b001, 3'b001, 3'b111);
        chk("reset_btn", 32'(bus.btn_out), 32'h0);
        chk("reset_rgb", 32'({bus.R_out, bus.G_out, bus.B_out}), 32'h0);

        rst = 1'b0;
        step();
        push_rgb(12'h000);
        step_rgb("blank_rgb");
        chk("blank_btn", 32'(bus.btn_out), 32'h0);
        frame();
        frame();
        state_chk("first_active", 3'b001, 3'b001, 3'b110);
        chk("slot0_btn", 32'(bus.btn_out), 32'h00F);

        bus.btn_in = 4'b0000;
        push_rgb(12'hF0A);
        step_rgb("slot0_rgb");

        // Forward walk with wrap
        pulse(1'b1, 1'b0);
        state_chk("next1_sw", 3'b010, 3'b011, 3'b111);
        frame(); frame();
        state_chk("next1_act", 3'b010, 3'b011, 3'b101);
        pulse(1'b1, 1'b0);
        state_chk("next2_sw", 3'b100, 3'b111, 3'b111);
        frame(); frame();
        state_chk("next2_act", 3'b100, 3'b111, 3'b011);
        push_rgb(12'h3C7);
        step_rgb("slot2_rgb");
        pulse(1'b1, 1'b0);
        frame(); frame();
        state_chk("next3_wrap", 3'b001, 3'b001, 3'b110);

        // Backward wrap, blanking while switching
        pulse(1'b0, 1'b1);
        state_chk("prev_sw", 3'b100, 3'b111, 3'b111);
        bus.btn_in = 4'b1111;
        #1;
        chk("prev_sw_btn", 32'(bus.btn_out), 32'h0);
        push_rgb(12'h000);
        step_rgb("prev_sw_rgb");
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
        chk("prev_sw_btn2", 32'(bus.btn_out), 32'h0);
        chk("prev_sw_rst2", 32'(bus.func_rst), 32'h7);
        frame();
        state_chk("prev_act", 3'b100, 3'b111, 3'b011);
        bus.btn_in = 4'b0000;

        pulse(1'b0, 1'b1);
        frame(); frame();
        state_chk("idx1_act", 3'b010, 3'b011, 3'b101);

        // Simultaneous edges are ignored
        pulse(1'b1, 1'b1);
        state_chk("both_edges", 3'b010, 3'b011, 3'b101);
        step();
        state_chk("both_edges2", 3'b010, 3'b011, 3'b101);

        bus.btn_in = 4'b0101;
        #1;
        chk("demux_idx1", 32'(bus.btn_out), 32'h050);
        bus.btn_in = 4'b0000;

        push_rgb(12'h5A3);
        step_rgb("slot1_rgb");
        bus.power_sw = 1'b0;
        push_rgb(12'h000);
        step_rgb("power_off_rgb");
        bus.power_sw = 1'b1;
        bus.pixel_en = 1'b0;
        push_rgb(12'h000);
        step_rgb("pixel_off_rgb");
        bus.pixel_en = 1'b1;
        push_rgb(12'h5A3);
        step_rgb("slot1_rgb_again");

        // Reset mid-switch at index 2 with one frame counted
        pulse(1'b1, 1'b0);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        state_chk("pre_reset", 3'b100, 3'b111, 3'b111);
        #2;
        rst = 1'b1;
        #1;
        state_chk("async_reset", 3'b001, 3'b001, 3'b111);
        chk("async_reset_rgb", 32'({bus.R_out, bus.G_out, bus.B_out}), 32'h0);
        step();
        rst = 1'b0;

        // Held frame_tick: counts two frames, then the exit edge must not add a third
        bus.frame_tick = 1'b1;
        step();
        chk("rel_f1_rst", 32'(bus.func_rst), 32'h7);
        step();
        chk("rel_f2_rst", 32'(bus.func_rst), 32'h7);
        step();
        bus.frame_tick = 1'b0;
        state_chk("rel_active", 3'b001, 3'b001, 3'b110);
        push_rgb(12'hF0A);
        step_rgb("rel_rgb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
